// File: rtl/hold_queue_pkg.sv
// Shared types and constants for the hold_queue request assembler and its FIFO.
package hold_queue_pkg;

    localparam int CMD_NOP = 0;

    typedef enum logic {
        IDLE = 1'b0,
        OP2  = 1'b1
    } asm_state_t;

    // One extra bit so a full FIFO (count == DEPTH) is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hold_fifo.sv
// Synchronous FIFO, falling-edge clocked, with occupancy count; head read straight from storage.
module hold_fifo
    import hold_queue_pkg::*;
#(
    parameter int WIDTH = 70,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              din,
    output logic [WIDTH-1:0]              dout,
    output logic                          full,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(negedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(negedge clk) begin
        if (!reset && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/hold_queue.sv
// Two-beat request assembler feeding a DEPTH-entry FIFO with sticky overflow/protocol flags.
// Optional HOLDQ_ERR_CNT_EN adds saturating drop_cnt / perr_cnt event counters.
module hold_queue
    import hold_queue_pkg::*;
#(
    parameter int CMD_W  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 2,
    parameter int DEPTH  = 4
) (
    input  logic                          c_clk,
    input  logic                          reset,
    input  logic [CMD_W-1:0]              req_cmd_in,
    input  logic [TAG_W-1:0]              req_tag_in,
    input  logic [DATA_W-1:0]             req_data_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CMD_W-1:0]              out_cmd,
    output logic [TAG_W-1:0]              out_tag,
    output logic [DATA_W-1:0]             out_data1,
    output logic [DATA_W-1:0]             out_data2,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          overflow,
    output logic                          proto_err
`ifdef HOLDQ_ERR_CNT_EN
    ,
    output logic [7:0]                    drop_cnt,
    output logic [7:0]                    perr_cnt
`endif
);
    localparam int E_W = CMD_W + TAG_W + 2 * DATA_W;

    asm_state_t        state;
    logic [CMD_W-1:0]  cmd_q;
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] data1_q;
    logic [E_W-1:0]    entry;
    logic [E_W-1:0]    head;
    logic              cmd_nz;
    logic              done;
    logic              pop;
    logic              full;
    logic              empty;
    logic              drop;
    logic              perr;

    assign cmd_nz = (req_cmd_in != CMD_W'(CMD_NOP));
    assign done   = (state == OP2);
    assign entry  = {cmd_q, tag_q, data1_q, req_data_in};
    assign pop    = out_valid && out_ready;
    assign drop   = done && full && !pop;
    assign perr   = done && cmd_nz;

    hold_fifo #(
        .WIDTH (E_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (c_clk),
        .reset (reset),
        .push  (done),
        .pop   (pop),
        .din   (entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Storage is not cleared on reset, so the head is masked whenever empty.
    assign out_valid = !empty;
    assign out_data2 = out_valid ? head[DATA_W-1:0] : '0;
    assign out_data1 = out_valid ? head[2*DATA_W-1:DATA_W] : '0;
    assign out_tag   = out_valid ? head[2*DATA_W +: TAG_W] : '0;
    assign out_cmd   = out_valid ? head[2*DATA_W+TAG_W +: CMD_W] : '0;

    always_ff @(negedge c_clk) begin
        if (reset) begin
            state     <= IDLE;
            cmd_q     <= '0;
            tag_q     <= '0;
            data1_q   <= '0;
            overflow  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_nz) begin
                    cmd_q   <= req_cmd_in;
                    tag_q   <= req_tag_in;
                    data1_q <= req_data_in;
                    state   <= OP2;
                end
                OP2:     state <= IDLE;
                default: state <= IDLE;
            endcase
            if (drop) overflow  <= 1'b1;
            if (perr) proto_err <= 1'b1;
        end
    end

`ifdef HOLDQ_ERR_CNT_EN
    always_ff @(negedge c_clk) begin
        if (reset) begin
            drop_cnt <= '0;
            perr_cnt <= '0;
        end else begin
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            if (perr && perr_cnt != 8'hFF) perr_cnt <= perr_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hold_queue.sv
// Directed bench for hold_queue: queue-based reference model checked every cycle plus literal spot checks.
// Covers HOLDQ_ERR_CNT_EN counters when the macro is defined.
module tb_hold_queue;
    localparam int CMD_W  = 4;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 2;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    typedef struct {
        logic [CMD_W-1:0]  cmd;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
    } entry_t;

    logic              c_clk = 1'b1;
    logic              reset = 1'b1;
    logic [CMD_W-1:0]  req_cmd_in = '0;
    logic [TAG_W-1:0]  req_tag_in = '0;
    logic [DATA_W-1:0] req_data_in = '0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [CMD_W-1:0]  out_cmd;
    logic [TAG_W-1:0]  out_tag;
    logic [DATA_W-1:0] out_data1;
    logic [DATA_W-1:0] out_data2;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              proto_err;
`ifdef HOLDQ_ERR_CNT_EN
    logic [7:0]        drop_cnt;
    logic [7:0]        perr_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    hold_queue #(
        .CMD_W  (CMD_W),
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W),
        .DEPTH  (DEPTH)
    ) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_tag_in  (req_tag_in),
        .req_data_in (req_data_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_cmd     (out_cmd),
        .out_tag     (out_tag),
        .out_data1   (out_data1),
        .out_data2   (out_data2),
        .count       (count),
        .overflow    (overflow),
        .proto_err   (proto_err)
`ifdef HOLDQ_ERR_CNT_EN
        ,
        .drop_cnt    (drop_cnt),
        .perr_cnt    (perr_cnt)
`endif
    );

    always #5 c_clk = ~c_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a request is pending after beat 1; the next cycle completes it.
    entry_t m_q[$];
    logic   m_pend = 1'b0;
    entry_t m_part;
    logic   m_ovf = 1'b0;
    logic   m_perr = 1'b0;
    int     m_drops = 0;
    int     m_perrs = 0;

    always @(negedge c_clk) begin
        if (reset) begin
            m_q.delete();
            m_pend  = 1'b0;
            m_ovf   = 1'b0;
            m_perr  = 1'b0;
            m_drops = 0;
            m_perrs = 0;
        end else begin
            logic popping;
            popping = (m_q.size() != 0) && out_ready;
            if (popping) void'(m_q.pop_front());
            if (m_pend) begin
                m_part.d2 = req_data_in;
                if (req_cmd_in != 0) begin
                    m_perr = 1'b1;
                    m_perrs++;
                end
                if (m_q.size() < DEPTH) m_q.push_back(m_part);
                else begin
                    m_ovf = 1'b1;
                    m_drops++;
                end
                m_pend = 1'b0;
            end else if (req_cmd_in != 0) begin
                m_part.cmd = req_cmd_in;
                m_part.tag = req_tag_in;
                m_part.d1  = req_data_in;
                m_pend     = 1'b1;
            end
        end
    end

    always @(posedge c_clk) begin
        entry_t h;
        h = '{cmd: '0, tag: '0, d1: '0, d2: '0};
        if (m_q.size() != 0) h = m_q[0];
        chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
        chk("out_cmd",   64'(out_cmd),   64'(h.cmd));
        chk("out_tag",   64'(out_tag),   64'(h.tag));
        chk("out_data1", 64'(out_data1), 64'(h.d1));
        chk("out_data2", 64'(out_data2), 64'(h.d2));
        chk("count",     64'(count),     64'(m_q.size()));
        chk("overflow",  64'(overflow),  64'(m_ovf));
        chk("proto_err", 64'(proto_err), 64'(m_perr));
`ifdef HOLDQ_ERR_CNT_EN
        chk("drop_cnt",  64'(drop_cnt),  64'(m_drops > 255 ? 255 : m_drops));
        chk("perr_cnt",  64'(perr_cnt),  64'(m_perrs > 255 ? 255 : m_perrs));
`endif
    end

    // Apply inputs for one cycle; returns just after the following active edge.
    task automatic cyc(input logic [CMD_W-1:0] c, input logic [TAG_W-1:0] t,
                       input logic [DATA_W-1:0] d, input logic rdy, input logic rst);
        req_cmd_in  = c;
        req_tag_in  = t;
        req_data_in = d;
        out_ready   = rdy;
        reset       = rst;
        @(negedge c_clk);
        #1;
    endtask

    task automatic req(input logic [CMD_W-1:0] c, input logic [TAG_W-1:0] t,
                       input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                       input logic rdy1, input logic rdy2);
        cyc(c, t, d1, rdy1, 1'b0);
        cyc('0, '0, d2, rdy2, 1'b0);
    endtask

    initial begin
        cyc('0, '0, '0, 1'b0, 1'b1);
        cyc('0, '0, '0, 1'b0, 1'b1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);

        // Single request, ready high: visible after the second edge, popped on the third.
        req(4'h1, 2'd2, 32'd5, 32'd3, 1'b1, 1'b1);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_head", {out_cmd, out_tag, 26'd0, out_data1[15:0], out_data2[15:0]},
            {4'h1, 2'd2, 26'd0, 16'd5, 16'd3});
        cyc('0, '0, '0, 1'b1, 1'b0);
        chk("t1_count", 64'(count), 64'd0);

        // Five back-to-back requests into a stalled FIFO: fifth dropped.
        for (int i = 1; i <= 5; i++)
            req(CMD_W'(i), TAG_W'(i), 32'h100 + 32'(i), 32'h200 + 32'(i), 1'b0, 1'b0);
        chk("t2_count", 64'(count), 64'd4);
        chk("t2_ovf", 64'(overflow), 64'd1);
        chk("t2_head_d1", 64'(out_data1), 64'h101);
        for (int i = 0; i < 6; i++) cyc('0, '0, '0, 1'b1, 1'b0);
        chk("t2_drained", 64'(count), 64'd0);

        // Full FIFO popped on the completion edge of a fifth request: no drop.
        cyc('0, '0, '0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++)
            req(CMD_W'(i + 8), 2'd1, 32'h300 + 32'(i), 32'h400 + 32'(i), 1'b0, 1'b0);
        req(4'hD, 2'd3, 32'h305, 32'h405, 1'b0, 1'b1);
        chk("t3_count", 64'(count), 64'd4);
        chk("t3_ovf", 64'(overflow), 64'd0);
        chk("t3_head_d1", 64'(out_data1), 64'h302);
        for (int i = 0; i < 6; i++) cyc('0, '0, '0, 1'b1, 1'b0);

        // Stray command on beat 2: flagged, taken as data2, not started.
        cyc(4'h3, 2'd1, 32'hAAAA, 1'b0, 1'b0);
        cyc(4'h2, 2'd3, 32'hBBBB, 1'b0, 1'b0);
        chk("t4_perr", 64'(proto_err), 64'd1);
        cyc('0, '0, 32'hCCCC, 1'b0, 1'b0);
        cyc('0, '0, 32'hDDDD, 1'b0, 1'b0);
        chk("t4_count", 64'(count), 64'd1);
        chk("t4_d2", 64'(out_data2), 64'hBBBB);

        // Reset during beat 2 discards the partial entry.
        cyc('0, '0, '0, 1'b0, 1'b1);
        cyc(4'h7, 2'd2, 32'h77, 1'b0, 1'b0);
        cyc('0, '0, 32'h88, 1'b0, 1'b1);
        chk("t5_count", 64'(count), 64'd0);
        chk("t5_flags", {62'd0, overflow, proto_err}, 64'd0);
        cyc('0, '0, '0, 1'b0, 1'b0);
        chk("t5_count2", 64'(count), 64'd0);
        req(4'h6, 2'd1, 32'h66, 32'h99, 1'b0, 1'b0);
        chk("t5_after", {out_cmd, out_data1[15:0], out_data2[15:0]}, {4'h6, 16'h66, 16'h99});
        chk("t5_after_cnt", 64'(count), 64'd1);

`ifdef HOLDQ_ERR_CNT_EN
        cyc('0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 304; i++) req(4'h5, 2'd0, 32'(i), 32'(i), 1'b0, 1'b0);
        chk("drop_sat", 64'(drop_cnt), 64'd255);
        chk("drop_sticky", 64'(overflow), 64'd1);
`endif

        cyc('0, '0, '0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hold_queue.md
# hold_queue

Parametrised successor to the calc1 hold register. It captures a two-beat request (a command with operand 1, then operand 2 on the next cycle) and assembles it into one entry. Entries are buffered in a DEPTH-entry FIFO and offered to the priority logic through a valid/ready handshake. The block adds a request tag, back-to-back buffering, overflow detection and protocol-error detection, none of which the single-entry hold stage has.

## Interface
Parameters:
- CMD_W, 4, command width; command 0 is NOP.
- DATA_W, 32, operand width.
- TAG_W, 2, request tag width.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- c_clk  in  1  clock; all state updates on falling edge of c_clk.
- reset  in  1  synchronous, active-high reset.
- req_cmd_in  in  CMD_W  command; nonzero marks beat 1.
- req_tag_in  in  TAG_W  tag, sampled with beat 1.
- req_data_in  in  DATA_W  operand 1 on beat 1, operand 2 on beat 2.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- out_cmd  out  CMD_W  head command.
- out_tag  out  TAG_W  head tag.
- out_data1  out  DATA_W  head operand 1.
- out_data2  out  DATA_W  head operand 2.
- count  out  $clog2(DEPTH)+1  occupied entries.
- overflow  out  1  sticky; a completed request was dropped because the FIFO was full.
- proto_err  out  1  sticky; nonzero command arrived on a beat-2 cycle.

## Operation
- Assembler FSM has two states, IDLE and OP2.
  - IDLE with req_cmd_in != 0: latch cmd, tag and data1; go to OP2.
  - IDLE with req_cmd_in == 0: stay.
  - OP2: take req_data_in as data2, complete the entry, return to IDLE unconditionally.
- OP2 with req_cmd_in != 0: set proto_err. The cycle is still treated as beat 2 and the stray command is ignored, not started.
- Completion with FIFO not full: push {cmd, tag, data1, data2}.
- Completion with FIFO full: drop the entry, set overflow, leave FIFO contents unchanged.
  - A pop in the same edge frees a slot, so full-and-popping is not a drop: push and pop both occur.
- Pop occurs on an edge where out_valid && out_ready.
  - out_valid = count != 0.
  - Head outputs are stable while out_valid && !out_ready.
- Push and pop on the same edge leave count unchanged.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.
- Outputs when count == 0: out_cmd, out_tag, out_data1 and out_data2 drive 0.
- Reset state: FSM IDLE, count 0, pointers 0, out_valid 0, all data outputs 0, overflow 0, proto_err 0.
- Reset mid-request, including in OP2, discards the partial entry.
- Reset dominates every concurrent event on the same edge.

## Timing
- Beat 1 sampled at edge N, beat 2 at edge N+1. Entry written at edge N+1.
- out_valid rises after edge N+1 when the FIFO was empty: two-edge latency from command.
- Back-to-back requests are sustained with no idle beat: command at N, N+2, N+4, and so on. Throughput is one request per 2 cycles.
- out_ready is combinationally used only for the pop enable. Nothing drives outputs combinationally from inputs.
- overflow and proto_err assert after the offending edge and clear only on reset.

## Configuration
- HOLDQ_ERR_CNT_EN defined:
  - Adds outputs drop_cnt[7:0] and perr_cnt[7:0].
  - Each increments on the same edge its sticky flag condition occurs and saturates at 255.
  - Both reset to 0.
- Undefined: neither port nor the counters exist. Sticky flags are unchanged.

## Structure
- Package hold_queue_pkg holds:
  - CMD_NOP constant;
  - the assembler state enum (IDLE, OP2);
  - a function computing count width from DEPTH.
- One sub-module, hold_fifo: a synchronous FIFO parametrised by width and DEPTH, with push, pop, full, empty and count.
  - Entry width is CMD_W+TAG_W+2*DATA_W.
- The assembler FSM and error flags live in hold_queue.

## Test plan
- Reset, then cmd=4'h1, tag=2, data 0x0000_0005 then 0x0000_0003, out_ready=1 → out_valid after edge 2 with {1, 2, 5, 3}; popped next edge; count returns to 0.
- DEPTH=4, out_ready=0, five back-to-back requests → count=4, fifth dropped, overflow=1. Then out_ready=1 → first four entries popped in order, none corrupted.
- Full FIFO with out_ready=1 while a fifth request completes → push and pop on the same edge, no overflow, count stays 4.
- Command 4'h2 on the beat-2 cycle → proto_err=1; data taken as data2; no extra entry created.
- reset asserted during OP2 → no entry pushed, all outputs 0. A new request after reset completes normally.
- With HOLDQ_ERR_CNT_EN, 300 overflow drops → drop_cnt saturates at 255.
